// File: rtl/c3_weight_loader.sv
// c3_weight_loader: streams NW*GP*NUM C3 weights from the weight ROM into the
// C3 weight buffer in ROM order, pacing reads itself because the buffer has no
// ready. Optional feature macro: C3_WLOAD_CHECKSUM_EN adds a 16-bit checksum of
// every emitted weight, compared against EXP_SUM when the load completes.
module c3_weight_loader #(
  parameter int          WD        = 8,
  parameter int          NW        = 25,
  parameter int          GP        = 6,
  parameter int          NUM       = 16,
  parameter int          AW        = 12,
  parameter int          BASE_ADDR = 0,
  parameter int          RD_LAT    = 1,
  parameter logic [15:0] EXP_SUM   = 16'h0000
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_hold,
  output logic          o_rom_en,
  output logic [AW-1:0] o_rom_addr,
  input  logic [WD-1:0] i_rom_data,
  output logic          c3_weight_en,
  output logic [WD-1:0] c3_weight_data,
  output logic          o_busy,
  output logic          o_done,
  output logic [11:0]   o_wcnt,
  output logic          o_chk_err
);

  localparam int              TOTAL   = NW * GP * NUM;
  localparam int              CW      = $clog2(TOTAL + 1);
  localparam logic [CW-1:0]   LAST_RD = CW'(TOTAL - 1);
  localparam logic [11:0]     TOTAL_W = 12'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     issue_cnt;
  logic [RD_LAT-1:0] vld;
  logic              rom_en_s;
  logic              load_start_s;
  logic              emit_s;

  // A start is only honoured while idle; the pipeline end marks an arriving byte.
  assign load_start_s = (state == S_IDLE) && i_start;
  assign emit_s       = vld[RD_LAT-1];

  // The hold gates the read strobe combinationally so a held cycle issues nothing.
  assign o_rom_en   = rom_en_s;
  assign o_rom_addr = AW'(BASE_ADDR) + AW'(issue_cnt);

  // Next-state and read-issue decode.
  always_comb begin
    state_nx = state;
    rom_en_s = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        rom_en_s = !i_hold;
        if (!i_hold && (issue_cnt == LAST_RD)) begin
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_DRAIN: begin
        if (c3_weight_en && (o_wcnt == TOTAL_W)) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_DRAIN;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Issue counter: cleared on start, advances once per issued read.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      issue_cnt <= '0;
    end else if (load_start_s) begin
      issue_cnt <= '0;
    end else if (rom_en_s) begin
      issue_cnt <= issue_cnt + CW'(1);
    end else begin
      issue_cnt <= issue_cnt;
    end
  end

  // In-flight read tracker; never stalled since the buffer cannot push back.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      vld <= '0;
    end else begin
      vld[0] <= rom_en_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Weight emission register; data is forced to zero whenever the strobe is low.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      c3_weight_en   <= 1'b0;
      c3_weight_data <= '0;
    end else if (emit_s) begin
      c3_weight_en   <= 1'b1;
      c3_weight_data <= i_rom_data;
    end else begin
      c3_weight_en   <= 1'b0;
      c3_weight_data <= '0;
    end
  end

  // Emitted-weight count; saturates at the total and holds through idle.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      o_wcnt <= 12'd0;
    end else if (load_start_s) begin
      o_wcnt <= 12'd0;
    end else if (emit_s && (o_wcnt != TOTAL_W)) begin
      o_wcnt <= o_wcnt + 12'd1;
    end else begin
      o_wcnt <= o_wcnt;
    end
  end

  // Status flags registered from the next state so they align with the state.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_busy <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      o_done <= (state_nx == S_DONE);
    end
  end

`ifdef C3_WLOAD_CHECKSUM_EN
  logic [15:0] chk_sum;

  // Modulo-2^16 accumulate of one weight byte.
  function automatic logic [15:0] chk_add(input logic [15:0] sum, input logic [WD-1:0] data);
    return sum + 16'(data);
  endfunction

  // Running checksum of every byte handed to the buffer in this load.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      chk_sum <= 16'h0000;
    end else if (load_start_s) begin
      chk_sum <= 16'h0000;
    end else if (emit_s) begin
      chk_sum <= chk_add(chk_sum, i_rom_data);
    end else begin
      chk_sum <= chk_sum;
    end
  end

  // Verdict latched on entry to DONE; the sum already holds the final byte there.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      o_chk_err <= 1'b0;
    end else if (load_start_s) begin
      o_chk_err <= 1'b0;
    end else if ((state == S_DRAIN) && (state_nx == S_DONE)) begin
      o_chk_err <= (chk_sum != EXP_SUM);
    end else begin
      o_chk_err <= o_chk_err;
    end
  end
`else
  assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_c3_weight_loader.sv
// Bench for c3_weight_loader: two instances (RD_LAT=1 base 0, RD_LAT=3 base 100)
// driven by a table of load scenarios plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_c3_weight_loader;

  localparam int TOTAL = 2400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn1, start1, hold1, ren1, wen1, busy1, done1, chk1;
  logic rstn3, start3, hold3, ren3, wen3, busy3, done3, chk3;
  logic [11:0] addr1, addr3, wcnt1, wcnt3;
  logic [7:0]  rd1, rd3, wd1, wd3, r3a, r3b;

  c3_weight_loader #(.RD_LAT(1), .BASE_ADDR(0), .EXP_SUM(16'h8D50)) u_dut1 (
    .i_sclk(clk), .i_rstn(rstn1), .i_start(start1), .i_hold(hold1),
    .o_rom_en(ren1), .o_rom_addr(addr1), .i_rom_data(rd1),
    .c3_weight_en(wen1), .c3_weight_data(wd1), .o_busy(busy1), .o_done(done1),
    .o_wcnt(wcnt1), .o_chk_err(chk1));

  c3_weight_loader #(.RD_LAT(3), .BASE_ADDR(100), .EXP_SUM(16'h8D4F)) u_dut3 (
    .i_sclk(clk), .i_rstn(rstn3), .i_start(start3), .i_hold(hold3),
    .o_rom_en(ren3), .o_rom_addr(addr3), .i_rom_data(rd3),
    .c3_weight_en(wen3), .c3_weight_data(wd3), .o_busy(busy3), .o_done(done3),
    .o_wcnt(wcnt3), .o_chk_err(chk3));

  // ROM image: word k (relative to base) holds k[7:0]; 0xEE when not read.
  function automatic logic [7:0] rom_val(input logic [11:0] a, input int base);
    logic [11:0] k;
    k = a - 12'(base);
    return k[7:0];
  endfunction

  always @(posedge clk) rd1 <= ren1 ? rom_val(addr1, 0) : 8'hEE;

  always @(posedge clk) begin
    r3a <= ren3 ? rom_val(addr3, 100) : 8'hEE;
    r3b <= r3a;
    rd3 <= r3b;
  end

  // Observation mux onto the instance under test.
  logic cur_sel;
  logic m_ren, m_wen, m_busy, m_done, m_chk;
  logic [11:0] m_addr, m_wcnt;
  logic [7:0] m_wd;
  assign m_ren  = cur_sel ? ren3  : ren1;
  assign m_wen  = cur_sel ? wen3  : wen1;
  assign m_busy = cur_sel ? busy3 : busy1;
  assign m_done = cur_sel ? done3 : done1;
  assign m_chk  = cur_sel ? chk3  : chk1;
  assign m_addr = cur_sel ? addr3 : addr1;
  assign m_wcnt = cur_sel ? wcnt3 : wcnt1;
  assign m_wd   = cur_sel ? wd3   : wd1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic int base_of(input int sel);
    return (sel == 0) ? 0 : 100;
  endfunction

  function automatic logic exp_chk_of(input int sel);
`ifdef C3_WLOAD_CHECKSUM_EN
    return (sel == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input int sel, input logic s, input logic h, input logic r);
    if (sel == 0) begin start1 = s; hold1 = h; rstn1 = r; end
    else          begin start3 = s; hold3 = h; rstn3 = r; end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rom_en"},  {31'd0, m_ren},  32'd0);
    check({tag, "_rom_addr"}, {20'd0, m_addr}, 32'(base_of(int'(cur_sel))));
    check({tag, "_wen"},     {31'd0, m_wen},  32'd0);
    check({tag, "_wdata"},   {24'd0, m_wd},   32'd0);
    check({tag, "_busy"},    {31'd0, m_busy}, 32'd0);
    check({tag, "_done"},    {31'd0, m_done}, 32'd0);
    check({tag, "_wcnt"},    {20'd0, m_wcnt}, 32'd0);
    check({tag, "_chk_err"}, {31'd0, m_chk},  32'd0);
  endtask

  // One full load with a cycle-accurate expectation built from the read schedule.
  task automatic run_load(input int sel, input int hc, input int hl, input int rc,
                          input int exp_done, input string tag);
    bit   rd_cyc [0:2600];
    int   lat, base, issued, emitted, last_emit, errs, first_bad;
    int   act_done, n_done, act_emits;
    logic hold_now, exp_ren, e_en, exp_busy, exp_dn;
    logic [7:0] exp_d, last_data;
    lat = lat_of(sel); base = base_of(sel);
    issued = 0; emitted = 0; last_emit = -1; errs = 0; first_bad = -1;
    act_done = -1; n_done = 0; act_emits = 0; last_data = 8'h00;
    cur_sel = (sel != 0);
    @(posedge clk); #1;
    drive(sel, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int n = 1; n <= 2440; n++) begin
      hold_now = (hl > 0) && (n >= hc) && (n < hc + hl);
      drive(sel, (n == rc), hold_now, 1'b1);
      exp_ren = (issued < TOTAL) && !hold_now;
      @(negedge clk);
      e_en  = (n > lat + 1) ? rd_cyc[n-lat-1] : 1'b0;
      exp_d = e_en ? 8'(emitted) : 8'h00;
      if (e_en) begin emitted++; last_emit = n; end
      exp_busy = (emitted < TOTAL) || e_en;
      exp_dn   = !e_en && (emitted == TOTAL) && (last_emit == n - 1);
      if ((m_ren !== exp_ren) || (exp_ren && (m_addr !== 12'(base + issued))) ||
          (m_wen !== e_en) || (m_wd !== exp_d) || (m_wcnt !== 12'(emitted)) ||
          (m_busy !== exp_busy) || (m_done !== exp_dn) || (m_busy && m_done)) begin
        errs++;
        if (first_bad < 0) first_bad = n;
      end
      if (exp_ren) begin rd_cyc[n] = 1'b1; issued++; end
      if (m_done) begin n_done++; if (act_done < 0) act_done = n; end
      if (m_wen) begin act_emits++; last_data = m_wd; end
      if (n == 1) check({tag, "_chk_err_cleared"}, {31'd0, m_chk}, 32'd0);
      if (n == exp_done) check({tag, "_chk_err_done"}, {31'd0, m_chk}, {31'd0, exp_chk_of(sel)});
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0, 1'b1);
    check($sformatf("%s_stream(first_bad_cycle=%0d)", tag, first_bad), errs, 0);
    check({tag, "_done_cycle"}, act_done, exp_done);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_emit_count"}, act_emits, TOTAL);
    check({tag, "_k16_c6_a24_byte"}, {24'd0, last_data}, 32'h5F);
    check({tag, "_wcnt_held"}, {20'd0, m_wcnt}, 32'd2400);
  endtask

  typedef struct {
    int sel;       // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
    int hc;        // first held cycle after start (0 = none)
    int hl;        // hold length in cycles
    int rc;        // cycle of an extra start pulse (0 = none)
    int exp_done;  // cycles from start to o_done
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 0,    0,  0,   2403};  // unheld, RD_LAT=1
    tbl[1] = '{1, 0,    0,  0,   2405};  // unheld, RD_LAT=3
    tbl[2] = '{1, 102,  10, 0,   2415};  // 10-cycle hold after read 100
    tbl[3] = '{0, 0,    0,  501, 2403};  // start re-pulsed at read 500
    tbl[4] = '{0, 2401, 3,  0,   2403};  // hold after the reads ran out
    tbl[5] = '{0, 2400, 3,  0,   2406};  // hold on the final read
    tbl[6] = '{1, 1,    5,  0,   2410};  // hold from the first issue cycle

    cur_sel = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    cur_sel = 1'b0; #1; check_reset_state("rst_lat1");
    cur_sel = 1'b1; #1; check_reset_state("rst_lat3");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_load(tbl[i].sel, tbl[i].hc, tbl[i].hl, tbl[i].rc, tbl[i].exp_done,
               $sformatf("v%0d", i));
    end

    // Reset in the cycle read 1234 is issued, then a fresh full reload.
    cur_sel = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b1);
    repeat (1234) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_read1234_en", {31'd0, m_ren}, 32'd1);
    check("midrst_read1234_addr", {20'd0, m_addr}, 32'd1234);
    check("midrst_wcnt_before", {20'd0, m_wcnt}, 32'd1233);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_reset_state("midrst_after");
    run_load(0, 0, 0, 0, 2403, "reload");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
